video_capture: RTL and testbench
================================

// Module: video_capture
// PURPOSE
//  Video sink: consumes the hsync/vsync/rgb stream the console drives out and
//  captures one armed frame into a pixel write port (framebuffer/checker RAM).
//  Also measures line length and lines-per-frame for timing self-checks.
//  Sits in the simulator/test top, downstream of the chip's video outputs.
// PARAMETERS
//  WIDTH     320  active pixels captured per line
//  HEIGHT    240  active lines captured per frame
//  H_BP      23   pix_ce ticks after hsync trailing edge before pixel 0
//  V_BP      5    hsync trailing edges after vsync trailing edge before line 0
//  SYNC_POL  1    1 = syncs active-high, 0 = active-low
//  AW        $clog2(WIDTH*HEIGHT)  write address width (derived)
// PORTS
//  clk_i       in   1   system clock
//  rst_ni      in   1   asynchronous, active-low reset
//  pix_ce      in   1   pixel clock enable; rgb sampled only when high
//  hsync       in   1   horizontal sync, polarity per SYNC_POL
//  vsync       in   1   vertical sync, polarity per SYNC_POL
//  rgb         in   24  pixel data {R[7:0],G[7:0],B[7:0]}
//  arm         in   1   1-cycle pulse: capture the next full frame
//  busy        out  1   high from accepted arm until DONE/abort
//  wr_en       out  1   pixel write strobe
//  wr_addr     out  AW  y*WIDTH + x
//  wr_data     out  24  captured pixel
//  frame_done  out  1   1-cycle pulse after last pixel written
//  timing_err  out  1   sticky; cleared by next accepted arm
//  line_len    out  12  pix_ce ticks between last two hsync leading edges
//  line_cnt    out  10  hsync leading edges between last two vsync leading edges
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0.
//  - Syncs normalised by SYNC_POL, registered once; edges found on clk_i.
//  - States: IDLE -arm-> WAIT_VS -vsync trailing-> V_PORCH
//    -V_BP hsync trailing-> ACTIVE -HEIGHT lines done-> DONE -1 cyc-> IDLE.
//  - V_BP=0: WAIT_VS goes straight to ACTIVE.
//  - ACTIVE line: hsync trailing edge starts H_BP countdown (pix_ce ticks);
//    then next WIDTH pix_ce samples are written, x=0..WIDTH-1.
//  - Latency: wr_en/addr/data registered, 1 clk after the sampling pix_ce.
//  - wr_addr is an incrementing counter (no multiplier); 0 at line 0 pixel 0,
//    WIDTH*HEIGHT-1 at last pixel; never wraps within a frame.
//  - frame_done pulses the clk after the last wr_en; busy falls same edge.
//  - arm ignored while busy; arm in IDLE clears timing_err.
//  - Abort: hsync leading edge before WIDTH pixels of a line written, or vsync
//    leading edge in V_PORCH/ACTIVE -> timing_err=1, back to IDLE, no
//    frame_done; already-issued writes stand.
//  - arm and abort same cycle: abort wins, arm dropped.
//  - Measurement runs always (any state): line_len/line_cnt load on their
//    leading edge, then count restarts at 1/0; counts saturate at all-ones.
//  - Async reset mid-frame: immediate IDLE, wr_en low, no partial pulse.
// STRUCTURE
//  - video_pkg: rgb888_t typedef, cap_state_e enum
//    {IDLE,WAIT_VS,V_PORCH,ACTIVE,DONE}, line_len/line_cnt widths.
//  - Sub-module sync_edge (register + leading/trailing pulse), one instance
//    per sync; FSM, counters and measurement stay in video_capture.
// TESTING
//  - Reset: rst_ni low mid-stream -> all outputs 0; released -> stays IDLE.
//  - Armed frame, WIDTH=4,HEIGHT=2,H_BP=2,V_BP=1, rgb=addr-indexed ramp ->
//    8 writes, addr 0..7, data match, frame_done once, busy low after.
//  - pix_ce every 4th clk (chip cadence) -> wr_en only 1 clk after each
//    sampled pix_ce; no writes between.
//  - Short line: hsync at pixel 2 of 4 -> timing_err=1, IDLE, no
//    frame_done; next arm clears timing_err.
//  - Measurement: 400-tick lines, 262-line frames -> line_len=400,
//    line_cnt=262 after second vsync; 5000-tick line -> line_len=4095.
//  - arm while busy and arm coincident with abort -> both ignored, one frame.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared types and widths for the video capture sink.
// Holds pixel/state typedefs and the measurement counter widths.
package video_pkg;

   localparam int LEN_W = 12;
   localparam int CNT_W = 10;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VS,
      V_PORCH,
      ACTIVE,
      DONE
   } cap_state_e;

   // bits needed to hold 0..n, never less than one
   function automatic int cw(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/video_capture_sync_edge.sv
// sync_edge: polarity-normalise and register one sync input,
// then flag its leading and trailing edges on the system clock.
module sync_edge #(
   parameter bit POL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_in,
   output logic lead,
   output logic trail
);

   logic s_q;
   logic d_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_q <= 1'b0;
         d_q <= 1'b0;
      end else begin
         s_q <= POL ? sync_in : ~sync_in;
         d_q <= s_q;
      end
   end

   assign lead  = s_q & ~d_q;
   assign trail = ~s_q & d_q;

endmodule

// File: rtl/video_capture.sv
// video_capture: captures one armed frame of an hsync/vsync/rgb stream
// into a pixel write port and measures line/frame timing.
module video_capture
   import video_pkg::*;
#(
   parameter int WIDTH    = 320,
   parameter int HEIGHT   = 240,
   parameter int H_BP     = 23,
   parameter int V_BP     = 5,
   parameter bit SYNC_POL = 1'b1,
   parameter int AW       = $clog2(WIDTH * HEIGHT)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pix_ce,
   input  logic             hsync,
   input  logic             vsync,
   input  logic [23:0]      rgb,
   input  logic             arm,
   output logic             busy,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [23:0]      wr_data,
   output logic             frame_done,
   output logic             timing_err,
   output logic [LEN_W-1:0] line_len,
   output logic [CNT_W-1:0] line_cnt
);

   localparam int XW  = cw(WIDTH - 1);
   localparam int YW  = cw(HEIGHT - 1);
   localparam int HBW = cw(H_BP);
   localparam int VBW = cw(V_BP);

   logic hs_lead, hs_trail;
   logic vs_lead, vs_trail;

   cap_state_e state_q, state_d;

   logic           in_line_q;
   logic [HBW-1:0] hbp_q;
   logic [VBW-1:0] vbp_q;
   logic [XW-1:0]  x_q;
   logic [YW-1:0]  y_q;
   logic [AW-1:0]  addr_q;

   logic           wr_en_q;
   logic [AW-1:0]  wr_addr_q;
   rgb888_t        wr_data_q;
   logic           frame_done_q;
   logic           terr_q;

   logic [LEN_W-1:0] hcnt_q, line_len_q;
   logic [CNT_W-1:0] vcnt_q, line_cnt_q;

   logic arm_ok, abort, start_line;
   logic take_pix, last_pix;

   sync_edge #(.POL(SYNC_POL)) u_hs (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sync_in (hsync),
      .lead    (hs_lead),
      .trail   (hs_trail)
   );

   sync_edge #(.POL(SYNC_POL)) u_vs (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sync_in (vsync),
      .lead    (vs_lead),
      .trail   (vs_trail)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      arm_ok     = 1'b0;
      abort      = 1'b0;
      start_line = 1'b0;
      take_pix   = 1'b0;
      last_pix   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arm) begin
               arm_ok  = 1'b1;
               state_d = WAIT_VS;
            end
         end
         WAIT_VS: begin
            if (vs_trail)
               state_d = (V_BP == 0) ? ACTIVE : V_PORCH;
         end
         V_PORCH: begin
            if (vs_lead)
               abort = 1'b1;
            else if (hs_trail && vbp_q == VBW'(1))
               state_d = ACTIVE;
         end
         ACTIVE: begin
            // a new line starting before this one is full is a timing fault
            if (vs_lead || (hs_lead && in_line_q)) begin
               abort = 1'b1;
            end else if (!in_line_q) begin
               start_line = hs_trail;
            end else if (pix_ce && hbp_q == '0) begin
               take_pix = 1'b1;
               if (x_q == XW'(WIDTH - 1)) begin
                  last_pix = 1'b1;
                  if (y_q == YW'(HEIGHT - 1))
                     state_d = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_line_q    <= 1'b0;
         hbp_q        <= '0;
         vbp_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         terr_q       <= 1'b0;
      end else begin
         wr_en_q      <= take_pix;
         frame_done_q <= (state_q == DONE);
         if (arm_ok)     terr_q <= 1'b0;
         else if (abort) terr_q <= 1'b1;
         if (take_pix) begin
            wr_addr_q <= addr_q;
            wr_data_q <= rgb;
         end
         if (state_q == WAIT_VS)
            vbp_q <= VBW'(V_BP);
         else if (state_q == V_PORCH && hs_trail)
            vbp_q <= vbp_q - 1'b1;
         if (arm_ok) begin
            addr_q    <= '0;
            y_q       <= '0;
            in_line_q <= 1'b0;
         end else if (abort) begin
            in_line_q <= 1'b0;
         end else if (start_line) begin
            in_line_q <= 1'b1;
            hbp_q     <= HBW'(H_BP);
            x_q       <= '0;
         end else if (take_pix) begin
            addr_q <= addr_q + 1'b1;
            x_q    <= x_q + 1'b1;
            if (last_pix) begin
               in_line_q <= 1'b0;
               y_q       <= y_q + 1'b1;
            end
         end else if (in_line_q && pix_ce && hbp_q != '0) begin
            hbp_q <= hbp_q - 1'b1;
         end
      end
   end

   // free-running timing measurement, independent of capture state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hcnt_q     <= '0;
         line_len_q <= '0;
         vcnt_q     <= '0;
         line_cnt_q <= '0;
      end else begin
         if (hs_lead) begin
            line_len_q <= hcnt_q;
            hcnt_q     <= pix_ce ? LEN_W'(1) : '0;
         end else if (pix_ce && hcnt_q != '1) begin
            hcnt_q <= hcnt_q + 1'b1;
         end
         if (vs_lead) begin
            line_cnt_q <= vcnt_q;
            vcnt_q     <= hs_lead ? CNT_W'(1) : '0;
         end else if (hs_lead && vcnt_q != '1) begin
            vcnt_q <= vcnt_q + 1'b1;
         end
      end
   end

   assign busy       = (state_q != IDLE);
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign timing_err = terr_q;
   assign line_len   = line_len_q;
   assign line_cnt   = line_cnt_q;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed table-driven bench for video_capture
// on a 4x2 frame with H_BP=2, V_BP=1.
module tb_video_capture;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int HBP = 2;
   localparam int VBP = 1;
   localparam int AW  = 3;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          pix_ce = 1'b0;
   logic          hsync = 1'b0;
   logic          vsync = 1'b0;
   logic [23:0]   rgb = '0;
   logic          arm = 1'b0;
   logic          busy, wr_en, frame_done, timing_err;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_data;
   logic [11:0]   line_len;
   logic [9:0]    line_cnt;

   always #5 clk = ~clk;

   video_capture #(
      .WIDTH(W), .HEIGHT(H), .H_BP(HBP), .V_BP(VBP), .SYNC_POL(1'b1)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .pix_ce     (pix_ce),
      .hsync      (hsync),
      .vsync      (vsync),
      .rgb        (rgb),
      .arm        (arm),
      .busy       (busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .timing_err (timing_err),
      .line_len   (line_len),
      .line_cnt   (line_cnt)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } wr_vec_t;

   typedef struct {
      int          ticks;
      int          lines;
      logic [11:0] len;
      logic [9:0]  cnt;
   } meas_vec_t;

   wr_vec_t   wr_tab[8];
   meas_vec_t meas_tab[4];

   int checks = 0;
   int errors = 0;
   int clk_n = 0;
   int arm_clk = -1;
   int cad = 4;

   logic [AW-1:0] q_addr[$];
   logic [23:0]   q_data[$];
   int   fd_cnt = 0;
   int   lat_bad = 0;
   int   fd_bad = 0;
   logic ce_q = 1'b0;
   logic wr_q = 1'b0;
   logic busy_q = 1'b0;

   always @(posedge clk) ce_q <= pix_ce;

   // write/done monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_ni) begin
         if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            if (!ce_q) lat_bad <= lat_bad + 1;
         end
         if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            if (!wr_q || busy || !busy_q) fd_bad <= fd_bad + 1;
         end
      end
      wr_q   <= wr_en;
      busy_q <= busy;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic hs, input logic vs, input logic ce,
                       input logic [23:0] d);
      @(negedge clk);
      hsync  = hs;
      vsync  = vs;
      pix_ce = ce;
      rgb    = d;
      arm    = (clk_n == arm_clk);
      clk_n++;
   endtask

   task automatic tick(input logic hs, input logic vs, input logic [23:0] d);
      step(hs, vs, 1'b1, d);
      for (int i = 1; i < cad; i++) step(hs, vs, 1'b0, d);
   endtask

   function automatic logic [23:0] ramp(input int a);
      return 24'h102030 + 24'h010101 * 24'(a);
   endfunction

   // 2 sync ticks then 10 ticks; pixel x sits at tick x+3
   task automatic cap_line(input int l, input logic vs, input int cut,
                           input bit arm_abort);
      tick(1'b1, vs, 24'h0);
      tick(1'b1, vs, 24'h0);
      for (int k = 0; k < 10; k++) begin
         int y;
         int x;
         logic [23:0] d;
         y = l - (VBP + 1);
         x = k - 3;
         if (y >= 0 && y < H && x >= 0 && x < W) d = ramp(y * W + x);
         else d = 24'hEE0000 | 24'(k);
         if (arm_abort && k == cut) arm_clk = clk_n + 1;
         tick((cut >= 0 && k >= cut), vs, d);
      end
   endtask

   task automatic cap_frame(input int cut_line, input int cut,
                            input bit arm_abort, input int arm_line);
      for (int l = 0; l < 6; l++) begin
         if (l == arm_line) arm_clk = clk_n;
         cap_line(l, (l == 0), (l == cut_line) ? cut : -1,
                  arm_abort && (l == cut_line));
      end
   endtask

   task automatic do_arm();
      arm_clk = clk_n;
      step(hsync, vsync, 1'b0, rgb);
      step(hsync, vsync, 1'b0, rgb);
   endtask

   task automatic clear_mon();
      q_addr.delete();
      q_data.delete();
      fd_cnt  = 0;
      lat_bad = 0;
      fd_bad  = 0;
   endtask

   task automatic check_frame(input string tag, input int n, input int fds);
      chk({tag, " wr_count"}, q_addr.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] a;
         logic [23:0] d;
         a = (i < q_addr.size()) ? q_addr[i] : 'x;
         d = (i < q_data.size()) ? q_data[i] : 'x;
         chk($sformatf("%s addr%0d", tag, i), a, wr_tab[i].addr);
         chk($sformatf("%s data%0d", tag, i), d, wr_tab[i].data);
      end
      chk({tag, " frame_done"}, fd_cnt, fds);
      chk({tag, " done_timing"}, fd_bad, 0);
      chk({tag, " wr_latency"}, lat_bad, 0);
      chk({tag, " busy_after"}, busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " wr_en"}, wr_en, 0);
      chk({tag, " frame_done"}, frame_done, 0);
      chk({tag, " timing_err"}, timing_err, 0);
      chk({tag, " addr_data"}, {wr_addr, wr_data}, 0);
      chk({tag, " line_len"}, line_len, 0);
      chk({tag, " line_cnt"}, line_cnt, 0);
   endtask

   initial begin
      wr_tab[0] = '{3'd0, 24'h102030};
      wr_tab[1] = '{3'd1, 24'h112131};
      wr_tab[2] = '{3'd2, 24'h122232};
      wr_tab[3] = '{3'd3, 24'h132333};
      wr_tab[4] = '{3'd4, 24'h142434};
      wr_tab[5] = '{3'd5, 24'h152535};
      wr_tab[6] = '{3'd6, 24'h162636};
      wr_tab[7] = '{3'd7, 24'h172737};
      meas_tab[0] = '{400, 4, 12'd400, 10'd4};
      meas_tab[1] = '{20, 262, 12'd20, 10'd262};
      meas_tab[2] = '{5000, 2, 12'd4095, 10'd2};
      meas_tab[3] = '{8, 1030, 12'd8, 10'd1023};

      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);

      // plain armed frame
      clear_mon();
      do_arm();
      chk("arm busy", busy, 1);
      cap_frame(-1, -1, 1'b0, -1);
      check_frame("frame1", 8, 1);
      chk("frame1 terr", timing_err, 0);

      // extra arm while capturing is ignored
      clear_mon();
      do_arm();
      cap_frame(-1, -1, 1'b0, 3);
      check_frame("frame2", 8, 1);

      // short line aborts; arm on the abort edge is dropped
      clear_mon();
      do_arm();
      cap_frame(2, 5, 1'b1, -1);
      check_frame("abort", 3, 0);
      chk("abort terr", timing_err, 1);

      clear_mon();
      do_arm();
      chk("rearm terr", timing_err, 0);
      chk("rearm busy", busy, 1);
      cap_frame(-1, -1, 1'b0, -1);
      check_frame("frame3", 8, 1);

      // async reset while a pixel strobe is high
      clear_mon();
      do_arm();
      cap_line(0, 1'b1, -1, 1'b0);
      cap_line(1, 1'b0, -1, 1'b0);
      tick(1'b1, 1'b0, 24'h0);
      tick(1'b1, 1'b0, 24'h0);
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 24'hEE0000 | 24'(k));
      step(1'b0, 1'b0, 1'b1, ramp(0));
      @(posedge clk);
      #2;
      chk("pre_rst wr_en", wr_en, 1);
      rst_ni = 1'b0;
      #1;
      chk_zero("mid_rst");
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      clear_mon();
      cap_frame(-1, -1, 1'b0, -1);
      chk("post_rst busy", busy, 0);
      chk("post_rst writes", q_addr.size(), 0);
      chk("post_rst done", fd_cnt, 0);

      // measurement at pix_ce every clock
      cad = 1;
      for (int e = 0; e < 4; e++) begin
         for (int f = 0; f < 2; f++)
            for (int l = 0; l < meas_tab[e].lines; l++)
               for (int k = 0; k < meas_tab[e].ticks; k++)
                  step((k < 2), (l == 0), 1'b1, 24'h0);
         step(1'b1, 1'b1, 1'b1, 24'h0);
         step(1'b1, 1'b1, 1'b1, 24'h0);
         step(1'b0, 1'b0, 1'b1, 24'h0);
         step(1'b0, 1'b0, 1'b1, 24'h0);
         chk($sformatf("meas%0d line_len", e), line_len, meas_tab[e].len);
         chk($sformatf("meas%0d line_cnt", e), line_cnt, meas_tab[e].cnt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
